// File: rtl/fila_chamadas_pkg.sv
// Shared definitions for the elevator request buffer: floor codes, presentation
// FSM states and the one-hot validity test.
package fila_chamadas_pkg;

  localparam logic [3:0] ANDAR1 = 4'b0001;
  localparam logic [3:0] ANDAR2 = 4'b0010;
  localparam logic [3:0] ANDAR3 = 4'b0100;
  localparam logic [3:0] ANDAR4 = 4'b1000;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ORIGEM  = 2'd1,
    DESTINO = 2'd2,
    RECUO   = 2'd3
  } estado_t;

  // A floor field is legal only if it names exactly one of the four floors.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v == ANDAR1) || (v == ANDAR2) || (v == ANDAR3) || (v == ANDAR4);
  endfunction

endpackage

// File: rtl/fila_circular.sv
// Parameterised DEPTH x W synchronous circular FIFO; head word is visible
// combinationally on dado_o whenever the FIFO is not empty.
module fila_circular #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             dado_i,
  output logic [W-1:0]             dado_o,
  output logic [$clog2(DEPTH):0]   nivel_o,
  output logic                     cheio_o,
  output logic                     vazio_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   nivel_q;
  logic          wr_en, rd_en;

  assign cheio_o = (nivel_q == (AW+1)'(DEPTH));
  assign vazio_o = (nivel_q == '0);
  assign nivel_o = nivel_q;
  assign dado_o  = mem_q[rd_q];

  assign wr_en = push_i && (!cheio_o || pop_i);
  assign rd_en = pop_i && !vazio_o;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= dado_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      nivel_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   nivel_q <= nivel_q + 1'b1;
        2'b01:   nivel_q <= nivel_q - 1'b1;
        default: nivel_q <= nivel_q;
      endcase
    end
  end

endmodule

// File: rtl/fila_chamadas.sv
// Request buffer ahead of the elevator datapath: validates and queues floor pairs,
// then replays each as separated one-hot origin/destination button pulses.
module fila_chamadas
  import fila_chamadas_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int HOLD    = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 2000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             painel_origem,
  input  logic [3:0]             painel_destino,
  input  logic                   painel_valido,
  output logic                   painel_pronto,
  input  logic                   uc_ack,
  output logic [3:0]             origemBot,
  output logic [3:0]             destinoBot,
  output logic                   ocupado,
  output logic [$clog2(DEPTH):0] nivel,
  output logic                   erro_invalido,
  output logic                   erro_timeout
);

  localparam int MAXC = (HOLD > GAP) ? ((HOLD > TIMEOUT) ? HOLD : TIMEOUT)
                                     : ((GAP > TIMEOUT) ? GAP : TIMEOUT);
  localparam int CW   = $clog2(MAXC) + 1;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    entrada, cabeca, held_q, ultimo_q;
  logic [3:0]    origem_q, origem_d, destino_q, destino_d;
  logic          erro_inv_q, erro_to_q, erro_to_d;
  logic          aceita, par_valido, coalesce, push, pop, cheio, vazio;

  assign entrada    = {painel_origem, painel_destino};
  assign aceita     = painel_valido && painel_pronto;
  assign par_valido = is_one_hot(painel_origem) && is_one_hot(painel_destino)
                      && (painel_origem != painel_destino);
  // While anything is queued, the newest queued entry is always the last one written.
  assign coalesce   = (nivel != '0) && (entrada == ultimo_q);
  assign push       = aceita && par_valido && !coalesce;

  fila_circular #(.DEPTH(DEPTH), .W(8)) u_fila (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .dado_i  (entrada),
    .dado_o  (cabeca),
    .nivel_o (nivel),
    .cheio_o (cheio),
    .vazio_o (vazio)
  );

  assign painel_pronto = !cheio;
  assign ocupado       = (estado_q != OCIOSO);
  assign origemBot     = origem_q;
  assign destinoBot    = destino_q;
  assign erro_invalido = erro_inv_q;
  assign erro_timeout  = erro_to_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      held_q     <= '0;
      ultimo_q   <= '0;
      origem_q   <= '0;
      destino_q  <= '0;
      erro_inv_q <= 1'b0;
      erro_to_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      if (pop)  held_q   <= cabeca;
      if (push) ultimo_q <= entrada;
      origem_q   <= origem_d;
      destino_q  <= destino_d;
      erro_inv_q <= aceita && !par_valido;
      erro_to_q  <= erro_to_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    pop      = 1'b0;
    unique case (estado_q)
      OCIOSO: if (!vazio) begin
        estado_d = ORIGEM;
        pop      = 1'b1;
      end
      ORIGEM:  if (cnt_q == CW'(HOLD - 1)) estado_d = DESTINO;
      DESTINO: if (uc_ack || (cnt_q == CW'(TIMEOUT - 1))) estado_d = RECUO;
      RECUO:   if (cnt_q == CW'(GAP - 1)) estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    cnt_d = (estado_d != estado_q || estado_q == OCIOSO) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    origem_d  = (estado_q == ORIGEM)  ? held_q[7:4] : '0;
    destino_d = (estado_q == DESTINO) ? held_q[3:0] : '0;
    erro_to_d = (estado_q == DESTINO) && !uc_ack && (cnt_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: tb/tb_fila_chamadas.sv
// Directed self-checking bench for the fila_chamadas request buffer.
module tb_fila_chamadas;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] painel_origem = '0, painel_destino = '0;
  logic       painel_valido = 1'b0, uc_ack = 1'b0;
  logic       painel_pronto, ocupado, erro_invalido, erro_timeout;
  logic [3:0] origemBot, destinoBot, nivel;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fila_chamadas #(.DEPTH(8), .HOLD(4), .GAP(2), .TIMEOUT(2000)) dut (
    .clock          (clock),
    .reset          (reset),
    .painel_origem  (painel_origem),
    .painel_destino (painel_destino),
    .painel_valido  (painel_valido),
    .painel_pronto  (painel_pronto),
    .uc_ack         (uc_ack),
    .origemBot      (origemBot),
    .destinoBot     (destinoBot),
    .ocupado        (ocupado),
    .nivel          (nivel),
    .erro_invalido  (erro_invalido),
    .erro_timeout   (erro_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] o, input logic [3:0] d);
    painel_origem  = o;
    painel_destino = d;
    painel_valido  = 1'b1;
    tick();
    painel_valido  = 1'b0;
  endtask

  task automatic ack;
    uc_ack = 1'b1;
    tick();
    uc_ack = 1'b0;
  endtask

  // which: 0 origemBot nonzero, 1 destinoBot nonzero, 2 ocupado low
  task automatic wait_for(input int which);
    for (int n = 0; n < 3000; n++) begin
      if ((which == 0 && origemBot != '0) || (which == 1 && destinoBot != '0) ||
          (which == 2 && !ocupado)) return;
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total_cnt++; if ({origemBot, destinoBot} !== 8'h00) $display("FAIL reset_pins got %h want 00", {origemBot, destinoBot}); else pass_cnt++;
    total_cnt++; if (nivel !== 4'd0) $display("FAIL reset_nivel got %0d want 0", nivel); else pass_cnt++;
    total_cnt++; if (painel_pronto !== 1'b1) $display("FAIL reset_pronto got %b want 1", painel_pronto); else pass_cnt++;
    total_cnt++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got %b want 0", ocupado); else pass_cnt++;
    total_cnt++; if ({erro_invalido, erro_timeout} !== 2'b00) $display("FAIL reset_erros got %b want 00", {erro_invalido, erro_timeout}); else pass_cnt++;
  endtask

  task automatic test_basic;
    int hold;
    push(4'b0001, 4'b0100);
    total_cnt++; if (nivel !== 4'd1) $display("FAIL basic_nivel_push got %0d want 1", nivel); else pass_cnt++;
    wait_for(0);
    total_cnt++; if (origemBot !== 4'b0001) $display("FAIL basic_origem got %b want 0001", origemBot); else pass_cnt++;
    total_cnt++; if (ocupado !== 1'b1 || nivel !== 4'd0) $display("FAIL basic_busy got ocupado=%b nivel=%0d want 1/0", ocupado, nivel); else pass_cnt++;
    hold = 0;
    while (origemBot == 4'b0001 && hold < 20) begin hold++; tick(); end
    total_cnt++; if (hold !== 4) $display("FAIL basic_hold got %0d want 4", hold); else pass_cnt++;
    total_cnt++; if ({origemBot, destinoBot} !== 8'h04) $display("FAIL basic_destino got %h want 04", {origemBot, destinoBot}); else pass_cnt++;
    repeat (5) tick();
    total_cnt++; if (destinoBot !== 4'b0100) $display("FAIL basic_destino_hold got %b want 0100", destinoBot); else pass_cnt++;
    ack();
    total_cnt++; if (destinoBot !== 4'b0100) $display("FAIL basic_ack_lag got %b want 0100", destinoBot); else pass_cnt++;
    tick();
    total_cnt++; if ({destinoBot, ocupado} !== 5'b0000_1) $display("FAIL basic_gap1 got %b want 00001", {destinoBot, ocupado}); else pass_cnt++;
    tick();
    total_cnt++; if ({origemBot, destinoBot, ocupado, nivel} !== 13'd0) $display("FAIL basic_idle got %h want 0", {origemBot, destinoBot, ocupado, nivel}); else pass_cnt++;
  endtask

  task automatic test_invalid;
    push(4'b0010, 4'b0010);
    total_cnt++; if (erro_invalido !== 1'b1) $display("FAIL inv_same_erro got %b want 1", erro_invalido); else pass_cnt++;
    tick();
    total_cnt++; if (erro_invalido !== 1'b0) $display("FAIL inv_pulse_len got %b want 0", erro_invalido); else pass_cnt++;
    push(4'b0011, 4'b1000);
    total_cnt++; if (erro_invalido !== 1'b1) $display("FAIL inv_multi_erro got %b want 1", erro_invalido); else pass_cnt++;
    tick(); tick();
    total_cnt++; if ({origemBot, destinoBot, ocupado, nivel, erro_invalido} !== 14'd0) $display("FAIL inv_quiet got %h want 0", {origemBot, destinoBot, ocupado, nivel, erro_invalido}); else pass_cnt++;
  endtask

  task automatic test_fill;
    logic [3:0] eo [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] ed [9] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    for (int i = 0; i < 8; i++) push(eo[i], ed[i]);
    total_cnt++; if ({nivel, painel_pronto} !== 5'b0111_1) $display("FAIL fill_7 got nivel=%0d pronto=%b want 7/1", nivel, painel_pronto); else pass_cnt++;
    push(eo[8], ed[8]);
    total_cnt++; if ({nivel, painel_pronto} !== 5'b1000_0) $display("FAIL fill_full got nivel=%0d pronto=%b want 8/0", nivel, painel_pronto); else pass_cnt++;
    push(4'b1000, 4'b0001);
    tick();
    total_cnt++; if ({nivel, erro_invalido} !== 5'b1000_0) $display("FAIL fill_blocked got nivel=%0d erro=%b want 8/0", nivel, erro_invalido); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        wait_for(0);
        total_cnt++; if (origemBot !== eo[i]) $display("FAIL fill_origem_%0d got %b want %b", i, origemBot, eo[i]); else pass_cnt++;
        total_cnt++; if (nivel !== 4'(8 - i)) $display("FAIL fill_nivel_%0d got %0d want %0d", i, nivel, 8 - i); else pass_cnt++;
      end
      wait_for(1);
      total_cnt++; if (destinoBot !== ed[i]) $display("FAIL fill_destino_%0d got %b want %b", i, destinoBot, ed[i]); else pass_cnt++;
      ack();
    end
    wait_for(2);
    total_cnt++; if ({nivel, painel_pronto, ocupado} !== 6'b0000_10) $display("FAIL fill_drained got %b want 000010", {nivel, painel_pronto, ocupado}); else pass_cnt++;
  endtask

  task automatic test_timeout;
    int held, pulses, gap;
    push(4'b1000, 4'b0010);
    push(4'b0100, 4'b0001);
    wait_for(1);
    held = 0; pulses = 0;
    while (destinoBot != '0 && held < 2100) begin
      held++;
      if (erro_timeout) pulses++;
      tick();
    end
    if (erro_timeout) pulses++;
    total_cnt++; if (held !== 2000) $display("FAIL to_duration got %0d want 2000", held); else pass_cnt++;
    total_cnt++; if (pulses !== 1) $display("FAIL to_pulses got %0d want 1", pulses); else pass_cnt++;
    gap = 0;
    while (origemBot == '0 && gap < 20) begin gap++; tick(); end
    total_cnt++; if (gap !== 3) $display("FAIL to_gap got %0d want 3", gap); else pass_cnt++;
    total_cnt++; if (origemBot !== 4'b0100) $display("FAIL to_next_origem got %b want 0100", origemBot); else pass_cnt++;
    wait_for(1);
    ack();
    wait_for(2);
  endtask

  task automatic test_coalesce;
    logic [3:0] ed [3] = '{4'b1000, 4'b0001, 4'b1000};
    push(4'b0010, 4'b1000);
    tick(); tick();
    push(4'b1000, 4'b0001);
    push(4'b1000, 4'b0001);
    total_cnt++; if ({nivel, erro_invalido} !== 5'b0001_0) $display("FAIL coal_dup got nivel=%0d erro=%b want 1/0", nivel, erro_invalido); else pass_cnt++;
    push(4'b0001, 4'b1000);
    total_cnt++; if (nivel !== 4'd2) $display("FAIL coal_new got %0d want 2", nivel); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_for(0);
      wait_for(1);
      total_cnt++; if (destinoBot !== ed[i]) $display("FAIL coal_order_%0d got %b want %b", i, destinoBot, ed[i]); else pass_cnt++;
      ack();
    end
    wait_for(2);
    total_cnt++; if (nivel !== 4'd0) $display("FAIL coal_drained got %0d want 0", nivel); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    push(4'b0001, 4'b0010);
    push(4'b0010, 4'b0100);
    push(4'b0100, 4'b1000);
    push(4'b1000, 4'b0001);
    total_cnt++; if ({origemBot, nivel} !== 8'b0001_0011) $display("FAIL rmid_pre got origem=%b nivel=%0d want 0001/3", origemBot, nivel); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if ({origemBot, destinoBot, nivel, ocupado} !== 13'd0 || painel_pronto !== 1'b1) $display("FAIL rmid_flush got %h pronto=%b want 0/1", {origemBot, destinoBot, nivel, ocupado}, painel_pronto); else pass_cnt++;
    repeat (4) tick();
    total_cnt++; if ({origemBot, ocupado, nivel} !== 9'd0) $display("FAIL rmid_stays_idle got %h want 0", {origemBot, ocupado, nivel}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_fill();
    test_timeout();
    test_coalesce();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
